// File: rtl/sobel_filter_pkg.sv
// sobel_pkg: frame geometry, pixel/gradient types and the small arithmetic
// helpers shared by the Sobel datapath and its line buffers.
// Types: pixel_t (8b), grad_t (signed 11b), mag_t (unsigned 11b), window_t (3x3).
package sobel_pkg;

  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int PIX_W = 8;
  localparam int IO_W  = 10;

  typedef logic [PIX_W-1:0]          pixel_t;
  typedef logic signed [10:0]        grad_t;
  typedef logic [10:0]               mag_t;
  // Indexed [row][col]; row 0 is the oldest line, col 0 the oldest column.
  typedef logic [2:0][2:0][PIX_W-1:0] window_t;

  // 1-2-1 weighted sum of three pixels; max 1020, so it is always a
  // non-negative value inside the signed 11-bit gradient range.
  function automatic grad_t weighted_sum(pixel_t a, pixel_t b, pixel_t c);
    return grad_t'({3'b000, a}) + grad_t'({2'b00, b, 1'b0}) + grad_t'({3'b000, c});
  endfunction

  // |g| for g in -1020..1020 always fits the unsigned 11-bit magnitude.
  function automatic mag_t abs_grad(grad_t g);
    return g[10] ? mag_t'(-g) : mag_t'(g);
  endfunction

  function automatic pixel_t saturate(mag_t m);
    return (m > mag_t'(255)) ? pixel_t'(255) : m[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_filter_if.sv
// sobel_filter_if: pixel stream bundle between source, filter and sink.
// Signals: pin (input pixel, [7:0] used), control (1 = Sobel, 0 = bypass),
// pout (result pixel, [9:8] always 0). master = source/sink side, slave = filter.
interface sobel_filter_if;
  import sobel_pkg::*;

  logic [IO_W-1:0] pin;
  logic            control;
  logic [IO_W-1:0] pout;

  modport master (output pin, output control, input pout);
  modport slave  (input pin, input control, output pout);

endinterface

// File: rtl/sobel_filter_line_buffer.sv
// sobel_line_buffer: fixed DEPTH-cycle pixel delay line built on one RAM.
// Ports: clock, reset_n (pointer only), i_din (pixel in), o_dout (i_din from DEPTH edges ago).
// No stalls: one write and one read per clock; RAM contents are not reset.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = IMG_W
) (
  input  logic   clock,
  input  logic   reset_n,
  input  pixel_t i_din,
  output pixel_t o_dout
);

  localparam int AW = $clog2(DEPTH);

  pixel_t          r_mem [DEPTH];
  logic [AW-1:0]   r_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (r_ptr == AW'(DEPTH - 1)) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  // Read-before-write on the same address: the location about to be
  // overwritten holds exactly the sample written DEPTH edges earlier.
  always_ff @(posedge clock) begin
    r_mem[r_ptr] <= i_din;
  end

  assign o_dout = r_mem[r_ptr];

endmodule

// File: rtl/sobel_filter.sv
// sobel_filter: streaming 3x3 Sobel edge detector, |Gx|+|Gy| saturated to 8 bits.
// Ports: clock, reset_n (async, active-low), bus (slave: pin, control -> pout).
// Latency LINE_W+4 cycles, one pixel per clock, no stalls; control selects Sobel or bypass.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int LINE_W  = IMG_W,
  parameter int FRAME_H = IMG_H
) (
  input  logic         clock,
  input  logic         reset_n,
  sobel_filter_if.slave bus
);

  localparam int LAT = LINE_W + 4;
  localparam int CW  = $clog2(LINE_W);
  localparam int RW  = $clog2(FRAME_H);
  localparam int FW  = $clog2(LAT + 1);

  pixel_t w_pix;
  logic   w_unused_pin_hi;

  assign w_pix           = bus.pin[PIX_W-1:0];
  assign w_unused_pin_hi = ^bus.pin[IO_W-1:PIX_W];

  // ---------------------------------------------------------------
  // Input position counters: index of the pixel sampled at this edge
  // ---------------------------------------------------------------
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_col == CW'(LINE_W - 1)) begin
      r_col <= '0;
      r_row <= (r_row == RW'(FRAME_H - 1)) ? '0 : r_row + 1'b1;
    end else begin
      r_col <= r_col + 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Line buffers: mid row is one line old, top row two lines old
  // ---------------------------------------------------------------
  pixel_t w_lb_mid;
  pixel_t w_lb_top;

  sobel_line_buffer #(.DEPTH(LINE_W)) u_lb_mid (
    .clock   (clock),
    .reset_n (reset_n),
    .i_din   (w_pix),
    .o_dout  (w_lb_mid)
  );

  sobel_line_buffer #(.DEPTH(LINE_W)) u_lb_top (
    .clock   (clock),
    .reset_n (reset_n),
    .i_din   (w_lb_mid),
    .o_dout  (w_lb_top)
  );

  // ---------------------------------------------------------------
  // 3x3 window: new column enters at col 2, centre is [1][1]
  // ---------------------------------------------------------------
  window_t r_win;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_win <= '0;
    end else begin
      for (int rr = 0; rr < 3; rr++) begin
        r_win[rr][0] <= r_win[rr][1];
        r_win[rr][1] <= r_win[rr][2];
      end
      r_win[0][2] <= w_lb_top;
      r_win[1][2] <= w_lb_mid;
      r_win[2][2] <= w_pix;
    end
  end

  // ---------------------------------------------------------------
  // Centre coordinates: the window centre seen by stage 1 is LINE_W+2
  // pixels behind the input counters, so step them back by that much.
  // ---------------------------------------------------------------
  logic [CW-1:0] w_ccol;
  logic [RW-1:0] w_crow;
  logic [RW-1:0] w_back;
  logic          w_border;

  always_comb begin
    w_ccol = (r_col >= CW'(2)) ? r_col - CW'(2) : r_col + CW'(LINE_W - 2);
    w_back = (r_col >= CW'(2)) ? RW'(1) : RW'(2);
    // When FRAME_H is a power of two the cast wraps to 0, which is still
    // the correct modulo-FRAME_H result.
    w_crow = (r_row >= w_back) ? r_row - w_back : r_row + RW'(FRAME_H) - w_back;
    w_border = (w_ccol == '0) || (w_ccol == CW'(LINE_W - 1)) ||
               (w_crow == '0) || (w_crow == RW'(FRAME_H - 1));
  end

  // ---------------------------------------------------------------
  // Stage 1: kernels. control is taken together with the centre pixel.
  // ---------------------------------------------------------------
  grad_t w_gx;
  grad_t w_gy;

  always_comb begin
    w_gx = weighted_sum(r_win[0][2], r_win[1][2], r_win[2][2]) -
           weighted_sum(r_win[0][0], r_win[1][0], r_win[2][0]);
    w_gy = weighted_sum(r_win[2][0], r_win[2][1], r_win[2][2]) -
           weighted_sum(r_win[0][0], r_win[0][1], r_win[0][2]);
  end

  grad_t  r_gx;
  grad_t  r_gy;
  pixel_t r_s1_pix;
  logic   r_s1_ctl;
  logic   r_s1_bdr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gx     <= '0;
      r_gy     <= '0;
      r_s1_pix <= '0;
      r_s1_ctl <= 1'b0;
      r_s1_bdr <= 1'b0;
    end else begin
      r_gx     <= w_gx;
      r_gy     <= w_gy;
      r_s1_pix <= r_win[1][1];
      r_s1_ctl <= bus.control;
      r_s1_bdr <= w_border;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: magnitude
  // ---------------------------------------------------------------
  mag_t   r_mag;
  pixel_t r_s2_pix;
  logic   r_s2_ctl;
  logic   r_s2_bdr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mag    <= '0;
      r_s2_pix <= '0;
      r_s2_ctl <= 1'b0;
      r_s2_bdr <= 1'b0;
    end else begin
      r_mag    <= abs_grad(r_gx) + abs_grad(r_gy);
      r_s2_pix <= r_s1_pix;
      r_s2_ctl <= r_s1_ctl;
      r_s2_bdr <= r_s1_bdr;
    end
  end

  // ---------------------------------------------------------------
  // Stage 3: saturate, border zeroing, bypass mux, fill blanking
  // ---------------------------------------------------------------
  logic [FW-1:0]   r_fill;
  logic [IO_W-1:0] r_pout;

  // Counts edges since reset; once it reaches LAT the pipeline carries
  // real pixels and the output is released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fill <= '0;
    end else if (r_fill != FW'(LAT)) begin
      r_fill <= r_fill + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pout <= '0;
    end else if (r_fill != FW'(LAT)) begin
      r_pout <= '0;
    end else if (!r_s2_ctl) begin
      r_pout <= IO_W'(r_s2_pix);
    end else if (r_s2_bdr) begin
      r_pout <= '0;
    end else begin
      r_pout <= IO_W'(saturate(r_mag));
    end
  end

  assign bus.pout = r_pout;

endmodule

// File: tb/tb_sobel_filter.sv
// tb_sobel_filter: streams synthetic and random frames through sobel_filter
// and compares every output against a frame-level reference model, plus a
// table of known spot responses and a few hand-written reset/latency sequences.
module tb_sobel_filter;
  import sobel_pkg::*;

  localparam int W   = IMG_W;
  localparam int H   = 16;          // short frames so several fit the run
  localparam int LAT = W + 4;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  sobel_filter_if bus ();

  sobel_filter #(.LINE_W(W), .FRAME_H(H)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] pix_q [$];
  bit         ctl_q [$];
  logic [9:0] log_q [$];

  typedef struct {
    string name;
    int    test;
    int    row;
    int    col;
    int    expv;
  } spot_t;

  spot_t spots [$];

  task automatic check(string name, int got, int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, expv);
    end
  endtask

  function automatic int px(int k);
    return int'(pix_q[k]);
  endfunction

  // Expected pout after edge e, straight from the frame definition:
  // result k appears LAT edges after pixel k; control travels with the
  // pixel that is sampled while k sits in the window centre (k+W+2).
  function automatic int ref_out(int e);
    int k, r, c, gx, gy, mag;
    if (e < LAT) return 0;
    k = e - LAT;
    r = (k / W) % H;
    c = k % W;
    if (!ctl_q[k + W + 2]) return px(k);
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    gx = (px(k - W + 1) + 2 * px(k + 1) + px(k + W + 1)) -
         (px(k - W - 1) + 2 * px(k - 1) + px(k + W - 1));
    gy = (px(k + W - 1) + 2 * px(k + W) + px(k + W + 1)) -
         (px(k - W - 1) + 2 * px(k - W) + px(k - W + 1));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > 255) ? 255 : mag;
  endfunction

  function automatic void fill(int id, int n);
    bit ctl;
    int r, c;
    logic [7:0] v;
    pix_q.delete();
    ctl_q.delete();
    ctl = (id != 4);
    for (int k = 0; k < n; k++) begin
      r = (k / W) % H;
      c = k % W;
      case (id)
        0: v = 8'h80;
        1: v = (c < 320) ? 8'd0 : 8'd255;
        2: v = 8'(c % 256);
        3: v = (r == 10 && c == 10) ? 8'd100 : 8'd0;
        4: v = 8'd255;
        default: begin
          if ($urandom_range(0, 199) == 0) ctl = ~ctl;
          if (r % 4 < 2) v = 8'($urandom);
          else           v = 8'(c / 4 + r * 5 + int'($urandom_range(0, 3)));
        end
      endcase
      pix_q.push_back(v);
      ctl_q.push_back(ctl);
    end
  endfunction

  function automatic void add_spot(string n, int t, int r, int c, int x);
    spot_t s;
    s.name = n; s.test = t; s.row = r; s.col = c; s.expv = x;
    spots.push_back(s);
  endfunction

  // Reset, then stream n pixels starting at pixel 0 of a frame, checking
  // each output against the model and then the spot table for this test.
  task automatic run(int id, string name, int n);
    int e;
    log_q.delete();
    reset_n     = 1'b0;
    bus.pin     = '0;
    bus.control = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.pin     = {2'($urandom_range(0, 3)), pix_q[i]};
      bus.control = ctl_q[i];
      @(posedge clock);
      #1;
      log_q.push_back(bus.pout);
      check($sformatf("%s e=%0d", name, i), int'(bus.pout), ref_out(i));
      @(negedge clock);
    end
    foreach (spots[s]) begin
      if (spots[s].test == id) begin
        e = spots[s].row * W + spots[s].col + LAT;
        if (e < log_q.size())
          check(spots[s].name, int'(log_q[e]), spots[s].expv);
        else
          check({spots[s].name, " beyond stream"}, -1, spots[s].expv);
      end
    end
  endtask

  initial begin
    add_spot("uniform (1,1)",      0, 1, 1, 0);
    add_spot("uniform (2,300)",    0, 2, 300, 0);
    add_spot("uniform (0,5)",      0, 0, 5, 0);
    add_spot("step (2,319)",       1, 2, 319, 255);
    add_spot("step (2,320)",       1, 2, 320, 255);
    add_spot("step (2,318)",       1, 2, 318, 0);
    add_spot("step (2,321)",       1, 2, 321, 0);
    add_spot("step top border",    1, 0, 319, 0);
    add_spot("ramp (2,100)",       2, 2, 100, 8);
    add_spot("ramp (3,500)",       2, 3, 500, 8);
    add_spot("ramp left border",   2, 2, 0, 0);
    add_spot("ramp right border",  2, 2, 639, 0);
    add_spot("dot (10,9)",         3, 10, 9, 200);
    add_spot("dot (10,11)",        3, 10, 11, 200);
    add_spot("dot (9,9)",          3, 9, 9, 200);
    add_spot("dot (11,11)",        3, 11, 11, 200);
    add_spot("dot (9,10)",         3, 9, 10, 200);
    add_spot("dot (10,10)",        3, 10, 10, 0);
    add_spot("dot (12,12)",        3, 12, 12, 0);
    add_spot("bypass (0,0)",       4, 0, 0, 255);
    add_spot("bypass (0,639)",     4, 0, 639, 255);
    add_spot("bypass (1,0)",       4, 1, 0, 255);

    reset_n     = 1'b0;
    bus.pin     = '0;
    bus.control = 1'b0;
    #12;
    check("pout in reset", int'(bus.pout), 0);

    fill(0, 4 * W + LAT);  run(0, "uniform", 4 * W + LAT);
    fill(1, 4 * W + LAT);  run(1, "step",    4 * W + LAT);
    fill(2, 4 * W + LAT);  run(2, "ramp",    4 * W + LAT);
    fill(3, 13 * W + LAT); run(3, "dot",     13 * W + LAT);

    fill(4, 2 * W + LAT);  run(4, "bypass",  2 * W + LAT);
    check("bypass last fill cycle", int'(log_q[LAT - 1]), 0);
    check("bypass first result",    int'(log_q[LAT]), 255);

    // Reset asserted in the middle of the cycle that would take pixel 1000.
    fill(5, 1000);         run(5, "pre-reset", 1000);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset clears pout", int'(bus.pout), 0);

    // Fresh frame plus three lines of the next one: bottom border, frame
    // wrap and random control switching are all exercised here.
    fill(6, (H + 3) * W);  run(6, "random",    (H + 3) * W);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
